// File: rtl/phy_rx_align_pkg.sv
// phy_rx_align_pkg: default control characters and alignment states
// shared by the lane receive path.
package phy_rx_align_pkg;

    localparam logic [7:0] COM_DEF  = 8'hBC;
    localparam logic [7:0] IDLE_DEF = 8'h7C;
    localparam int         STATE_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        HUNT    = 2'd0,
        LOCKING = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

endpackage

// File: rtl/phy_rx_align_if.sv
// phy_rx_align_if: serial input and aligned parallel output of one lane.
// slave is the receiver side, master is the line/consumer side.
interface phy_rx_align_if #(
    parameter int DATA_W = 8
) ();

    logic              serial_in;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              active;
    logic              com_seen;

    modport master (
        output serial_in,
        input  data_out,
        input  valid_out,
        input  active,
        input  com_seen
    );

    modport slave (
        input  serial_in,
        output data_out,
        output valid_out,
        output active,
        output com_seen
    );

endinterface

// File: rtl/phy_rx_align.sv
// phy_rx_align: single-lane MSB-first deserializer that bit-slips onto COM,
// locks after LOCK_COUNT aligned COMs and emits non-control words.
module phy_rx_align
    import phy_rx_align_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] COM        = DATA_W'(COM_DEF),
    parameter logic [DATA_W-1:0] IDLE       = DATA_W'(IDLE_DEF),
    parameter int                LOCK_COUNT = 4
) (
    input logic           clk16f,
    input logic           reset_L,
    phy_rx_align_if.slave rx
);

    localparam int BW = $clog2(DATA_W);
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam logic [BW-1:0] LAST   = BW'(DATA_W - 1);
    localparam logic [CW-1:0] LOCK_N = CW'(LOCK_COUNT);

    state_t            state;
    logic [DATA_W-2:0] sr;
    logic [BW-1:0]     bit_cnt;
    logic [CW-1:0]     com_cnt;
    logic [DATA_W-1:0] nxt;
    logic              boundary;
    logic              is_com;
    logic              is_idle;
    logic              lock_done;

    // Only DATA_W-1 history bits are stored; the live bit completes the word.
    assign nxt       = {sr, rx.serial_in};
    assign is_com    = (nxt == COM);
    assign is_idle   = (nxt == IDLE);
    assign boundary  = (bit_cnt == LAST);
    assign lock_done = (state == LOCKING) && boundary && is_com
                       && (com_cnt + CW'(1) == LOCK_N);

    always_ff @(posedge clk16f or negedge reset_L) begin
        if (!reset_L) begin
            state   <= HUNT;
            sr      <= '0;
            bit_cnt <= '0;
            com_cnt <= '0;
        end else begin
            sr <= nxt[DATA_W-2:0];
            unique case (state)
                HUNT: begin
                    if (is_com) begin
                        bit_cnt <= '0;
                        com_cnt <= CW'(1);
                        state   <= LOCKING;
                    end
                end
                LOCKING: begin
                    bit_cnt <= boundary ? '0 : bit_cnt + BW'(1);
                    if (boundary) begin
                        if (!is_com) begin
                            com_cnt <= '0;
                            state   <= HUNT;
                        end else if (lock_done) begin
                            com_cnt <= LOCK_N;
                            state   <= ACTIVE;
                        end else begin
                            com_cnt <= com_cnt + CW'(1);
                        end
                    end
                end
                ACTIVE: begin
                    bit_cnt <= boundary ? '0 : bit_cnt + BW'(1);
                end
                default: state <= HUNT;
            endcase
        end
    end

    always_ff @(posedge clk16f or negedge reset_L) begin
        if (!reset_L) begin
            rx.data_out  <= '0;
            rx.valid_out <= 1'b0;
            rx.active    <= 1'b0;
            rx.com_seen  <= 1'b0;
        end else begin
            rx.valid_out <= 1'b0;
            rx.com_seen  <= 1'b0;
            rx.active    <= (state == ACTIVE) || lock_done;
            // COM is tested before IDLE so it wins if both are equal.
            unique case (1'b1)
                (state == HUNT): begin
                    rx.com_seen <= is_com;
                end
                (state == LOCKING): begin
                    rx.com_seen <= boundary && is_com;
                end
                (state == ACTIVE) && boundary: begin
                    if (is_com) begin
                        rx.com_seen <= 1'b1;
                    end else if (!is_idle) begin
                        rx.data_out  <= nxt;
                        rx.valid_out <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_phy_rx_align.sv
// tb_phy_rx_align: directed and random checks of phy_rx_align against
// a word-level reference model (8-bit lane) plus a 10-bit lane sweep.
module tb_phy_rx_align;

    localparam logic [7:0] C8   = 8'hBC;
    localparam logic [7:0] I8   = 8'h7C;
    localparam int         NLK  = 4;
    localparam logic [9:0] C10  = 10'h17C;
    localparam logic [9:0] W10  = 10'h2AA;

    logic clk16f  = 1'b0;
    logic reset_L = 1'b0;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    phy_rx_align_if #(.DATA_W(8))  rx8 ();
    phy_rx_align_if #(.DATA_W(10)) rx10 ();

    phy_rx_align dut8 (
        .clk16f  (clk16f),
        .reset_L (reset_L),
        .rx      (rx8)
    );

    phy_rx_align #(
        .DATA_W     (10),
        .COM        (C10),
        .LOCK_COUNT (2)
    ) dut10 (
        .clk16f  (clk16f),
        .reset_L (reset_L),
        .rx      (rx10)
    );

    always #5 clk16f = ~clk16f;

    // Reference model: word = last 8 received bits; after the first COM
    // every 8th bit closes a word.
    bit         m_hist[$];
    int         m_mode;
    int         m_phase;
    int         m_ncom;
    logic       m_valid;
    logic       m_com;
    logic [7:0] m_data;

    int         vq[$];
    int         vt[$];
    int         ct[$];
    int         c10;
    int         v10;
    int         d10;

    function automatic void model_reset();
        m_hist.delete();
        m_mode  = 0;
        m_phase = 0;
        m_ncom  = 0;
        m_valid = 1'b0;
        m_com   = 1'b0;
        m_data  = 8'h00;
    endfunction

    function automatic void model_step(input bit b);
        logic [7:0] w;
        m_valid = 1'b0;
        m_com   = 1'b0;
        m_hist.push_back(b);
        if (m_hist.size() > 8) void'(m_hist.pop_front());
        w = 8'h00;
        foreach (m_hist[i]) w = {w[6:0], m_hist[i]};
        if (m_mode == 0) begin
            if (w == C8) begin
                m_mode  = 1;
                m_ncom  = 1;
                m_phase = 0;
                m_com   = 1'b1;
            end
        end else begin
            m_phase = m_phase + 1;
            if (m_phase == 8) begin
                m_phase = 0;
                if (m_mode == 1) begin
                    if (w == C8) begin
                        m_ncom = m_ncom + 1;
                        m_com  = 1'b1;
                        if (m_ncom == NLK) m_mode = 2;
                    end else begin
                        m_ncom = 0;
                        m_mode = 0;
                    end
                end else if (w == C8) begin
                    m_com = 1'b1;
                end else if (w != I8) begin
                    m_data  = w;
                    m_valid = 1'b1;
                end
            end
        end
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic b8, input logic b10);
        rx8.serial_in  = b8;
        rx10.serial_in = b10;
        @(posedge clk16f);
        #1;
        cyc++;
        if (!reset_L) model_reset();
        else model_step(b8);
        if (rx8.valid_out === 1'b1) begin
            vq.push_back(int'(rx8.data_out));
            vt.push_back(cyc);
        end
        if (rx8.com_seen === 1'b1) ct.push_back(cyc);
        if (rx10.valid_out === 1'b1) begin
            v10++;
            d10 = int'(rx10.data_out);
        end
        if (rx10.com_seen === 1'b1) c10++;
        check("valid", 32'(rx8.valid_out), 32'(m_valid));
        check("data", 32'(rx8.data_out), 32'(m_data));
        check("active", 32'(rx8.active), 32'(m_mode == 2));
        check("com_seen", 32'(rx8.com_seen), 32'(m_com));
    endtask

    task automatic send8(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) cycle(w[i], 1'b0);
    endtask

    task automatic send10(input logic [9:0] w);
        for (int i = 9; i >= 0; i--) cycle(1'b0, w[i]);
    endtask

    task automatic clear_log();
        vq.delete();
        vt.delete();
        ct.delete();
    endtask

    task automatic pulse_reset();
        reset_L = 1'b0;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        reset_L = 1'b1;
    endtask

    task automatic lock_seq();
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) send8(C8);
    endtask

    initial begin
        model_reset();
        rx8.serial_in  = 1'b0;
        rx10.serial_in = 1'b0;

        // Reset held with random line activity.
        for (int k = 0; k < 3; k++)
            cycle(1'($urandom), 1'($urandom));
        check("rst_active10", 32'(rx10.active), 32'd0);
        reset_L = 1'b1;
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0);

        // Lock on four COMs after junk bits.
        clear_log();
        lock_seq();
        check("lock_pulses", 32'(ct.size()), 32'd4);
        if (ct.size() == 4) begin
            check("com_gap", 32'(ct[1] - ct[0]), 32'd8);
            check("com_span", 32'(ct[3] - ct[0]), 32'd24);
        end
        check("lock_active", 32'(rx8.active), 32'd1);

        // Data, IDLE and COM after lock.
        clear_log();
        send8(8'h12);
        send8(I8);
        send8(C8);
        send8(8'hA5);
        check("data_pulses", 32'(vq.size()), 32'd2);
        if (vq.size() == 2) begin
            check("data_first", 32'(vq[0]), 32'h12);
            check("data_second", 32'(vq[1]), 32'hA5);
            check("data_gap", 32'(vt[1] - vt[0]), 32'd24);
        end

        // Broken lock sequence.
        pulse_reset();
        send8(C8);
        send8(C8);
        send8(8'h00);
        check("broken_active", 32'(rx8.active), 32'd0);
        for (int k = 0; k < 3; k++) send8(C8);
        check("relock_partial", 32'(rx8.active), 32'd0);
        send8(C8);
        check("relock_active", 32'(rx8.active), 32'd1);

        // Asynchronous reset away from the clock edge, mid-word.
        send8(8'h5A);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        #3;
        reset_L = 1'b0;
        #1;
        check("async_active", 32'(rx8.active), 32'd0);
        check("async_data", 32'(rx8.data_out), 32'd0);
        check("async_valid", 32'(rx8.valid_out), 32'd0);
        model_reset();
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        reset_L = 1'b1;
        send8(8'h33);
        check("post_rst_active", 32'(rx8.active), 32'd0);
        lock_seq();
        check("post_rst_lock", 32'(rx8.active), 32'd1);

        // Random words while aligned.
        for (int k = 0; k < 40; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) send8(C8);
            else if (r == 1) send8(I8);
            else send8(8'($urandom));
        end

        // Random bit stream with COMs at random bit offsets.
        pulse_reset();
        for (int k = 0; k < 120; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                send8(C8);
            end else begin
                int n;
                n = int'($urandom_range(1, 6));
                for (int j = 0; j < n; j++) cycle(1'($urandom), 1'b0);
            end
        end

        // 10-bit lane, two-COM lock.
        pulse_reset();
        c10 = 0;
        v10 = 0;
        d10 = 0;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        send10(C10);
        check("w10_one_com", 32'(rx10.active), 32'd0);
        send10(C10);
        check("w10_active", 32'(rx10.active), 32'd1);
        check("w10_coms", 32'(c10), 32'd2);
        send10(W10);
        check("w10_valids", 32'(v10), 32'd1);
        check("w10_data", 32'(d10), 32'h2AA);
        send10(C10);
        check("w10_valids_end", 32'(v10), 32'd1);
        check("w10_coms_end", 32'(c10), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
